// File: rtl/ir_prefetch_queue_if.sv
// rtl/ir_prefetch_queue_if.sv - fetch/control handshake bundle for the instruction prefetch queue
interface ir_prefetch_queue_if #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 4,
  parameter int OPC_BITS = 4,
  parameter int CNT_W    = $clog2(DEPTH + 1)
);
  logic                wr_valid;
  logic                wr_ready;
  logic [WIDTH-1:0]    wr_data;
  logic                ld;
  logic                flush;
  logic [WIDTH-1:0]    ir_out;
  logic                ir_valid;
  logic [OPC_BITS-1:0] opcode;
  logic [CNT_W-1:0]    count;
  logic                full;
  logic                empty;

  // Queue side: consumes fetch/control requests, presents IR and status.
  modport slave (
    input  wr_valid, wr_data, ld, flush,
    output wr_ready, ir_out, ir_valid, opcode, count, full, empty
  );

  // Fetch/control side.
  modport master (
    output wr_valid, wr_data, ld, flush,
    input  wr_ready, ir_out, ir_valid, opcode, count, full, empty
  );
endinterface

// File: rtl/ir_prefetch_queue.sv
// rtl/ir_prefetch_queue.sv - circular prefetch queue feeding an architectural instruction register
module ir_prefetch_queue #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 4,
  parameter int OPC_BITS = 4,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  ir_prefetch_queue_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic             ir_valid_q, ir_valid_d;
  logic             full_w, empty_w;
  logic             do_push, do_pop;

  // Status comes only from the registered count, never from pointers or inputs.
  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);
  assign do_push = bus.wr_valid && !full_w;
  assign do_pop  = bus.ld && !empty_w;

  assign bus.wr_ready = !full_w;
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.count    = count_q;
  assign bus.ir_out   = ir_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.opcode   = ir_q[WIDTH-1 -: OPC_BITS];

  // Next-state for storage, pointers, count and IR; flush overrides everything.
  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    if (bus.flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      ir_d       = '0;
      ir_valid_d = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = bus.wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (bus.ld) begin
        if (do_pop) begin
          // Head is read from the old storage: no same-cycle write-to-IR bypass.
          ir_d       = mem_q[rd_ptr_q];
          ir_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        end else begin
          ir_valid_d = 1'b0;
        end
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // State registers with asynchronous discard of all contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end
endmodule

// File: tb/tb_ir_prefetch_queue.sv
// tb/tb_ir_prefetch_queue.sv - directed self-checking bench for ir_prefetch_queue
module tb_ir_prefetch_queue;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  ir_prefetch_queue_if #(.WIDTH(16), .DEPTH(4), .OPC_BITS(4)) bus ();

  ir_prefetch_queue #(.WIDTH(16), .DEPTH(4), .OPC_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic load();
    bus.ld = 1'b1;
    tick();
    bus.ld = 1'b0;
  endtask

  task automatic check_ir(input string tag, input logic [15:0] ir, input logic v, input logic [2:0] cnt);
    check({tag, ".ir"},    {16'h0, bus.ir_out}, {16'h0, ir});
    check({tag, ".vld"},   {31'h0, bus.ir_valid}, {31'h0, v});
    check({tag, ".opc"},   {28'h0, bus.opcode}, {28'h0, ir[15:12]});
    check({tag, ".count"}, {29'h0, bus.count}, {29'h0, cnt});
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.ld       = 1'b0;
    bus.flush    = 1'b0;
    tick();
    tick();

    // Power-on reset state
    check_ir("por", 16'h0000, 1'b0, 3'd0);
    check("por.empty", {31'h0, bus.empty}, 32'd1);
    check("por.full", {31'h0, bus.full}, 32'd0);
    check("por.wr_ready", {31'h0, bus.wr_ready}, 32'd1);
    reset = 1'b1;
    tick();

    // Asynchronous reset mid-stream with count = 3, ir_out = A123
    push(16'hA123);
    load();
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    check_ir("pre_rst", 16'hA123, 1'b1, 3'd3);
    reset = 1'b0;
    #1;
    check_ir("async_rst", 16'h0000, 1'b0, 3'd0);
    check("async_rst.empty", {31'h0, bus.empty}, 32'd1);
    check("async_rst.wr_ready", {31'h0, bus.wr_ready}, 32'd1);
    #2;
    reset = 1'b1;
    tick();

    // FIFO order
    push(16'h1001);
    push(16'h2002);
    push(16'h3003);
    check("order.count", {29'h0, bus.count}, 32'd3);
    load();
    check_ir("order1", 16'h1001, 1'b1, 3'd2);
    load();
    check_ir("order2", 16'h2002, 1'b1, 3'd1);
    load();
    check_ir("order3", 16'h3003, 1'b1, 3'd0);

    // Full, refused push, pointer wrap
    push(16'h0011);
    push(16'h0022);
    push(16'h0033);
    push(16'h0044);
    check("full.count", {29'h0, bus.count}, 32'd4);
    check("full.full", {31'h0, bus.full}, 32'd1);
    check("full.wr_ready", {31'h0, bus.wr_ready}, 32'd0);
    push(16'h0055);
    check("refused.count", {29'h0, bus.count}, 32'd4);
    load();
    check_ir("wrap1", 16'h0011, 1'b1, 3'd3);
    push(16'h0066);
    check("wrap.count", {29'h0, bus.count}, 32'd4);
    load();
    check_ir("wrap2", 16'h0022, 1'b1, 3'd3);
    load();
    check_ir("wrap3", 16'h0033, 1'b1, 3'd2);
    load();
    check_ir("wrap4", 16'h0044, 1'b1, 3'd1);
    load();
    check_ir("wrap5", 16'h0066, 1'b1, 3'd0);

    // Load while empty holds ir_out and drops ir_valid
    push(16'hBEEF);
    load();
    check_ir("beef", 16'hBEEF, 1'b1, 3'd0);
    load();
    check_ir("ld_empty", 16'hBEEF, 1'b0, 3'd0);
    check("ld_empty.empty", {31'h0, bus.empty}, 32'd1);

    // Simultaneous push and load at count = 2
    push(16'h00A0);
    push(16'h00B0);
    bus.wr_valid = 1'b1;
    bus.ld       = 1'b1;
    bus.wr_data  = 16'h00C0;
    tick();
    check_ir("sim1", 16'h00A0, 1'b1, 3'd2);
    bus.wr_data = 16'h00D0;
    tick();
    check_ir("sim2", 16'h00B0, 1'b1, 3'd2);
    bus.wr_data = 16'h00E0;
    tick();
    check_ir("sim3", 16'h00C0, 1'b1, 3'd2);
    bus.wr_data = 16'h00F0;
    tick();
    check_ir("sim4", 16'h00D0, 1'b1, 3'd2);
    bus.wr_valid = 1'b0;
    bus.ld       = 1'b0;
    load();
    check_ir("drain1", 16'h00E0, 1'b1, 3'd1);
    load();
    check_ir("drain2", 16'h00F0, 1'b1, 3'd0);

    // Simultaneous push and load at empty: push only
    bus.wr_valid = 1'b1;
    bus.ld       = 1'b1;
    bus.wr_data  = 16'h5A5A;
    tick();
    bus.wr_valid = 1'b0;
    bus.ld       = 1'b0;
    check_ir("sim_empty", 16'h00F0, 1'b0, 3'd1);
    load();
    check_ir("sim_empty_ld", 16'h5A5A, 1'b1, 3'd0);

    // Flush dominates same-cycle push and load
    push(16'h4101);
    push(16'h4202);
    push(16'h4303);
    check("pre_flush.count", {29'h0, bus.count}, 32'd3);
    bus.flush    = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'h7777;
    bus.ld       = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.wr_valid = 1'b0;
    bus.ld       = 1'b0;
    check_ir("flush", 16'h0000, 1'b0, 3'd0);
    check("flush.empty", {31'h0, bus.empty}, 32'd1);
    push(16'h8808);
    load();
    check_ir("post_flush", 16'h8808, 1'b1, 3'd0);
    load();
    check_ir("post_flush_empty", 16'h8808, 1'b0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ir_prefetch_queue.md
Name: ir_prefetch_queue

Overview:
- Parametrised successor to the single-word instruction register.
- Holds a DEPTH-entry circular queue of prefetched instruction words, plus an architectural IR stage that presents the current instruction to decode.
- Sits between instruction memory fetch (write side) and the control unit (ld/advance side).
- Adds a ready/valid handshake, occupancy count, flush for branches, and opcode/register-field extraction.

Parameters:
- WIDTH, 16, instruction word width in bits (>= 8).
- DEPTH, 4, queue entries; power of two, >= 2.
- OPC_BITS, 4, width of the opcode field taken from the MSBs of the IR.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- wr_valid  input  1  fetch side presents wr_data.
- wr_ready  output  1  queue can accept a word; equals !full.
- wr_data  input  WIDTH  fetched instruction word.
- ld  input  1  control unit requests the next instruction into the IR.
- flush  input  1  discard all queued words and invalidate the IR (taken branch).
- ir_out  output  WIDTH  current instruction register contents.
- ir_valid  output  1  ir_out holds a real instruction.
- opcode  output  OPC_BITS  equals ir_out[WIDTH-1 -: OPC_BITS]; combinational from ir_out.
- count  output  CNT_W  number of words in the queue, excluding the IR stage.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (reset low, asynchronous):
  - read pointer, write pointer, count, ir_valid and ir_out all go to 0.
  - wr_ready = 1, empty = 1, full = 0.
  - Reset asserted mid-operation discards all contents immediately, with no wait for clk.
- Push: wr_valid & wr_ready at the clk edge writes wr_data at the write pointer, increments the write pointer (mod DEPTH) and increments count.
  - wr_valid while full is ignored; no overwrite and no state change.
- Load:
  - ld & !empty at the edge: ir_out <= queue head, ir_valid <= 1, read pointer advances (mod DEPTH), count decrements.
  - ld & empty: ir_valid <= 0, ir_out holds its old value, pointers unchanged. There is no write-to-IR bypass; a same-cycle push goes into the queue only.
  - No ld: ir_out and ir_valid hold.
- Simultaneous push and load (both qualified): the write and read happen together and count is unchanged.
  - When full, wr_ready = 0, so only the load happens.
  - When empty, only the push happens and ir_valid <= 0.
- Latency:
  - A word pushed at edge N appears in ir_out at the first ld edge >= N+1.
  - Words leave in strict FIFO order.
- Flush:
  - At the edge, pointers and count go to 0, ir_valid <= 0 and ir_out <= 0.
  - Flush dominates any push or ld in the same cycle; a same-cycle wr_data is dropped.
- Pointer wrap:
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - full/empty come from count, never from pointer comparison.
- count, full, empty and wr_ready are derived from registered count, so they are glitch-free with no combinational path from wr_valid or ld.
- opcode follows ir_out with zero cycles of latency; it is 0 after reset or flush.

Test Plan:
- Reset:
  - Stimulus: drive reset low mid-stream with count = 3 and ir_out = 16'hA123.
  - Required: ir_out = 0, ir_valid = 0, count = 0, empty = 1, wr_ready = 1 immediately, before the next clk edge.
- Order:
  - Stimulus: push 16'h1001, 16'h2002, 16'h3003, then ld three times.
  - Required: ir_out sequence is 1001, 2002, 3003; opcode sequence is 1, 2, 3; count goes 3→2→1→0; ir_valid = 1 throughout.
- Full and wrap:
  - Stimulus: push 5 words 16'h0011..16'h0055 back-to-back with DEPTH = 4.
  - Required: the 5th push is refused, with wr_ready = 0 and full = 1 after 4 pushes.
  - Then ld, push 16'h0066, and ld four times. Required: outputs 0011, 0022, 0033, 0044, 0066, exercising pointer wrap.
- Simultaneous push and load:
  - Stimulus: with count = 2, assert wr_valid and ld together for 4 cycles.
  - Required: count stays 2; ir_out follows FIFO order.
  - Stimulus: at empty, do the same in one cycle. Required: ir_valid = 0, count = 1.
- Load when empty:
  - Stimulus: ld with empty = 1 and ir_out = 16'hBEEF.
  - Required: ir_valid = 0, ir_out stays BEEF, count stays 0.
- Flush priority:
  - Stimulus: count = 3, assert flush, wr_valid (16'h7777) and ld in the same cycle.
  - Required: count = 0, ir_out = 0, ir_valid = 0, and 7777 never appears on later loads.
